// File: rtl/device_bus_arbiter_pkg.sv
// Shared types for the Device bus arbiter: owner states, default widths and
// the per-master request bundle.
package device_bus_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } owner_e;

   // Sized for the default widths; the arbiter is instantiated at these widths.
   typedef struct packed {
      logic                  write;
      logic                  lock;
      logic [ADDR_W_DEF-1:0] addr;
      logic [DATA_W_DEF-1:0] wdata;
   } bus_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin tie-break: a lone requester wins, and on a tie the
// requester that was not served last wins.
module rr_arbiter2 (
   input  logic [1:0] req_i,
   input  logic       last_served_i,
   output logic [1:0] gnt_o
);

   always_comb begin
      gnt_o = 2'b00;
      case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11:   gnt_o = last_served_i ? 2'b01 : 2'b10;
         default: gnt_o = 2'b00;
      endcase
   end

endmodule

// File: rtl/device_bus_arbiter.sv
// Shares the single Device port between the CPU data port (m0) and the
// DMA/UART loader (m1) with round-robin, bus lock and a hold limit.
module device_bus_arbiter
   import device_bus_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int MAX_HOLD = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m0_write,
   input  logic              m0_lock,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_ack,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_rvalid,
   input  logic              m1_req,
   input  logic              m1_write,
   input  logic              m1_lock,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_rvalid,
   output logic              Device_Read,
   output logic              Device_Write,
   output logic [ADDR_W-1:0] MemBus_Address,
   output logic [DATA_W-1:0] MemBus_Write_Data,
   input  logic [DATA_W-1:0] Device_Read_Data,
   output owner_e            state_o,
   output logic              last_served_o
);

   localparam int HOLD_W = $clog2(MAX_HOLD + 1);

   // Handshake: mN_req is valid and mN_ack is ready; an access transfers in
   // every cycle where both are high, and the master holds req and payload
   // steady until it sees ack.

   owner_e            state_q, state_d;
   logic              last_served_q, last_served_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic              lock_q, lock_d;
   logic              m0_rvalid_q, m1_rvalid_q;
   logic [DATA_W-1:0] m0_rdata_q, m1_rdata_q;

   bus_req_t   req0, req1, cur;
   logic       own0, own1, cur_req, oth_req, acc;
   logic       m0_rd_acc, m1_rd_acc;
   logic [1:0] gnt;
   owner_e     other;

   rr_arbiter2 u_rr (
      .req_i         ({m1_req, m0_req}),
      .last_served_i (last_served_q),
      .gnt_o         (gnt)
   );

   always_comb begin
      req0    = '{write: m0_write, lock: m0_lock, addr: m0_addr, wdata: m0_wdata};
      req1    = '{write: m1_write, lock: m1_lock, addr: m1_addr, wdata: m1_wdata};
      own0    = (state_q == OWN0);
      own1    = (state_q == OWN1);
      cur     = own1 ? req1 : req0;
      cur_req = (own0 & m0_req) | (own1 & m1_req);
      oth_req = (own0 & m1_req) | (own1 & m0_req);
      acc     = cur_req;
      other   = own0 ? OWN1 : OWN0;
   end

   assign m0_ack            = own0 & m0_req;
   assign m1_ack            = own1 & m1_req;
   assign Device_Read       = acc & ~cur.write;
   assign Device_Write      = acc & cur.write;
   assign MemBus_Address    = cur.addr;
   assign MemBus_Write_Data = cur.wdata;
   assign m0_rd_acc         = m0_ack & ~m0_write;
   assign m1_rd_acc         = m1_ack & ~m1_write;

   always_comb begin
      state_d       = state_q;
      last_served_d = last_served_q;
      hold_cnt_d    = hold_cnt_q;
      lock_d        = lock_q;
      case (state_q)
         IDLE: begin
            hold_cnt_d = '0;
            lock_d     = 1'b0;
            if (gnt[0])      state_d = OWN0;
            else if (gnt[1]) state_d = OWN1;
         end
         OWN0, OWN1: begin
            if (acc) begin
               lock_d = cur.lock;
               if (hold_cnt_q != HOLD_W'(MAX_HOLD)) hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
            if (!cur_req && !lock_q) begin
               state_d       = oth_req ? other : IDLE;
               last_served_d = own1;
               hold_cnt_d    = '0;
            end else if (acc && !cur.lock && oth_req &&
                         (hold_cnt_q >= HOLD_W'(MAX_HOLD - 1))) begin
               // Greater-or-equal also releases an owner whose count saturated while locked.
               state_d       = other;
               last_served_d = own1;
               hold_cnt_d    = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         last_served_q <= 1'b1;
         hold_cnt_q    <= '0;
         lock_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_served_q <= last_served_d;
         hold_cnt_q    <= hold_cnt_d;
         lock_q        <= lock_d;
      end
   end

   // Read return follows the master that was acked, even across a handover.
   always_ff @(posedge clk) begin
      if (reset) begin
         m0_rvalid_q <= 1'b0;
         m1_rvalid_q <= 1'b0;
         m0_rdata_q  <= '0;
         m1_rdata_q  <= '0;
      end else begin
         m0_rvalid_q <= m0_rd_acc;
         m1_rvalid_q <= m1_rd_acc;
         if (m0_rd_acc) m0_rdata_q <= Device_Read_Data;
         if (m1_rd_acc) m1_rdata_q <= Device_Read_Data;
      end
   end

   assign m0_rvalid     = m0_rvalid_q;
   assign m1_rvalid     = m1_rvalid_q;
   assign m0_rdata      = m0_rdata_q;
   assign m1_rdata      = m1_rdata_q;
   assign state_o       = state_q;
   assign last_served_o = last_served_q;

endmodule

// File: tb/tb_device_bus_arbiter.sv
// Directed bench for device_bus_arbiter: scripted masters, a write/read
// scoreboard checked at the Device port and rvalid, and per-cycle ack checks.
module tb_device_bus_arbiter;
   import device_bus_pkg::*;

   logic        clk, reset;
   logic        m0_req, m0_write, m0_lock, m1_req, m1_write, m1_lock;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic        m0_ack, m0_rvalid, m1_ack, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic        Device_Read, Device_Write;
   logic [31:0] MemBus_Address, MemBus_Write_Data, dev_rdata;
   owner_e      state_o;
   logic        last_served_o;

   device_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(8)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_write(m0_write), .m0_lock(m0_lock), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
      .m1_req(m1_req), .m1_write(m1_write), .m1_lock(m1_lock), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
      .Device_Read(Device_Read), .Device_Write(Device_Write),
      .MemBus_Address(MemBus_Address), .MemBus_Write_Data(MemBus_Write_Data),
      .Device_Read_Data(dev_rdata), .state_o(state_o), .last_served_o(last_served_o)
   );

   typedef struct {
      logic        write;
      logic        lock;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          gap;
   } tr_t;

   tr_t         m0_tr[$], m1_tr[$];
   logic [64:0] wr_q[$];
   logic [31:0] rd0_q[$], rd1_q[$];
   int          exp_ack[$], exp_rv[$], exp_ls[$];
   int          errors = 0;
   int          checks = 0;
   string       test_name = "reset";

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s/%s: observed=%0h expected=%0h", test_name, tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic add_tr(int m, logic w, logic l, logic [31:0] a, logic [31:0] d, int gap,
                         logic [31:0] rexp);
      tr_t t;
      t = '{write: w, lock: l, addr: a, wdata: d, gap: gap};
      if (m == 0) m0_tr.push_back(t); else m1_tr.push_back(t);
      if (w) wr_q.push_back({(m == 1), a, d});
      else if (m == 0) rd0_q.push_back(rexp);
      else rd1_q.push_back(rexp);
   endtask

   // ack/rv: bit0 = m0, bit1 = m1; ls < 0 means last_served is not checked.
   task automatic expc(int ack, int rv, int ls);
      exp_ack.push_back(ack);
      exp_rv.push_back(rv);
      exp_ls.push_back(ls);
   endtask

   task automatic run(int ncyc);
      int   g0, g1, ea, er, el;
      logic a0, a1, r0, r1;
      g0 = (m0_tr.size() > 0) ? m0_tr[0].gap : 0;
      g1 = (m1_tr.size() > 0) ? m1_tr[0].gap : 0;
      for (int c = 0; c < ncyc; c++) begin
         m0_req = (m0_tr.size() > 0) && (g0 == 0);
         m1_req = (m1_tr.size() > 0) && (g1 == 0);
         if (m0_req) begin
            m0_write = m0_tr[0].write; m0_lock = m0_tr[0].lock;
            m0_addr  = m0_tr[0].addr;  m0_wdata = m0_tr[0].wdata;
         end
         if (m1_req) begin
            m1_write = m1_tr[0].write; m1_lock = m1_tr[0].lock;
            m1_addr  = m1_tr[0].addr;  m1_wdata = m1_tr[0].wdata;
         end
         #1;
         ea = exp_ack.pop_front();
         er = exp_rv.pop_front();
         el = exp_ls.pop_front();
         chk($sformatf("ack_c%0d", c), {m1_ack, m0_ack}, ea[1:0]);
         chk($sformatf("rvalid_c%0d", c), {m1_rvalid, m0_rvalid}, er[1:0]);
         chk($sformatf("strobe_c%0d", c), Device_Read | Device_Write, (ea != 0));
         if (el >= 0) chk($sformatf("last_served_c%0d", c), last_served_o, el[0]);
         a0 = m0_ack; a1 = m1_ack; r0 = m0_req; r1 = m1_req;
         next_cycle();
         if (a0) begin
            m0_tr.delete(0);
            g0 = (m0_tr.size() > 0) ? m0_tr[0].gap : 0;
         end else if (!r0 && g0 > 0) g0--;
         if (a1) begin
            m1_tr.delete(0);
            g1 = (m1_tr.size() > 0) ? m1_tr[0].gap : 0;
         end else if (!r1 && g1 > 0) g1--;
      end
      m0_req = 1'b0;
      m1_req = 1'b0;
      chk("m0_script_done", m0_tr.size(), 0);
      chk("m1_script_done", m1_tr.size(), 0);
   endtask

   // Scoreboard: Device writes and read returns are matched against the queues.
   always @(negedge clk) begin
      if (Device_Write) begin
         if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
         else chk("wr_data", {m1_ack, MemBus_Address, MemBus_Write_Data}, wr_q.pop_front());
      end
      if (Device_Read | Device_Write) chk("strobe_owner", m0_ack | m1_ack, 1);
      if (m0_rvalid) begin
         if (rd0_q.size() == 0) chk("rd0_unexpected", 1, 0);
         else chk("rd0_data", m0_rdata, rd0_q.pop_front());
      end
      if (m1_rvalid) begin
         if (rd1_q.size() == 0) chk("rd1_unexpected", 1, 0);
         else chk("rd1_data", m1_rdata, rd1_q.pop_front());
      end
   end

   initial begin
      reset = 1'b1;
      m0_req = 0; m0_write = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0;
      m1_req = 0; m1_write = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;
      dev_rdata = '0;
      next_cycle();
      next_cycle();
      chk("state", state_o, IDLE);
      chk("last_served", last_served_o, 1'b1);
      chk("acks", {m1_ack, m0_ack}, 2'b00);
      chk("rvalids", {m1_rvalid, m0_rvalid}, 2'b00);
      chk("strobes", {Device_Write, Device_Read}, 2'b00);
      chk("m0_rdata", m0_rdata, 32'h0);
      chk("m1_rdata", m1_rdata, 32'h0);

      // Single m0 read; ack one cycle after req, rvalid the cycle after.
      test_name = "single_read";
      reset = 1'b0;
      dev_rdata = 32'hDEADBEEF;
      add_tr(0, 1'b0, 1'b0, 32'h40000010, 32'h0, 0, 32'hDEADBEEF);
      expc(0, 0, 1); expc(1, 0, -1); expc(0, 1, -1); expc(0, 0, 0);
      run(4);
      chk("state_after", state_o, IDLE);
      chk("m1_rdata_kept", m1_rdata, 32'h0);

      // Simultaneous requests after reset: m0 first, then m1 right after m0 drops.
      test_name = "tie_after_reset";
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      add_tr(0, 1'b1, 1'b0, 32'h40000100, 32'h00000A0A, 0, 32'h0);
      add_tr(1, 1'b1, 1'b0, 32'h40000200, 32'h00000B0B, 0, 32'h0);
      expc(0, 0, 1); expc(1, 0, -1); expc(0, 0, -1); expc(2, 0, 0); expc(0, 0, 0);
      run(5);

      // Hold limit: 20 unlocked m0 writes against a continuously requesting m1.
      test_name = "hold_limit";
      for (int k = 0; k < 8; k++)  add_tr(0, 1'b1, 1'b0, 32'h1000 + 4 * k, k, 0, 32'h0);
      for (int k = 0; k < 8; k++)  add_tr(1, 1'b1, 1'b0, 32'h2000 + 4 * k, 32'h100 + k, 0, 32'h0);
      for (int k = 8; k < 16; k++) add_tr(0, 1'b1, 1'b0, 32'h1000 + 4 * k, k, 0, 32'h0);
      for (int k = 8; k < 16; k++) add_tr(1, 1'b1, 1'b0, 32'h2000 + 4 * k, 32'h100 + k, 0, 32'h0);
      for (int k = 16; k < 20; k++) add_tr(0, 1'b1, 1'b0, 32'h1000 + 4 * k, k, 0, 32'h0);
      for (int k = 16; k < 24; k++) add_tr(1, 1'b1, 1'b0, 32'h2000 + 4 * k, 32'h100 + k, 0, 32'h0);
      expc(0, 0, 1);
      for (int b = 0; b < 4; b++)
         for (int k = 0; k < 8; k++) expc((b % 2 == 0) ? 1 : 2, 0, -1);
      for (int k = 0; k < 4; k++) expc(1, 0, -1);
      expc(0, 0, -1);
      for (int k = 0; k < 8; k++) expc(2, 0, 0);
      expc(0, 0, 0);
      run(47);

      // Locked read-modify-write by m0 keeps m1 off the bus through the gap.
      test_name = "locked_rmw";
      dev_rdata = 32'hCAFEF00D;
      add_tr(0, 1'b0, 1'b1, 32'h5000, 32'h0, 0, 32'hCAFEF00D);
      add_tr(0, 1'b1, 1'b0, 32'h5000, 32'h1234, 3, 32'h0);
      add_tr(1, 1'b1, 1'b0, 32'h3000, 32'hAAAA, 0, 32'h0);
      expc(0, 0, 1); expc(1, 0, -1); expc(0, 1, -1); expc(0, 0, -1); expc(0, 0, -1);
      expc(1, 0, -1); expc(0, 0, -1); expc(2, 0, 0); expc(0, 0, 0);
      run(9);

      // Read accepted at the hold limit returns to m0 while m1 takes the bus.
      test_name = "handover_read";
      dev_rdata = 32'h12345678;
      for (int k = 0; k < 7; k++) add_tr(0, 1'b1, 1'b0, 32'h6000 + 4 * k, 32'h600 + k, 0, 32'h0);
      add_tr(0, 1'b0, 1'b0, 32'h6020, 32'h0, 0, 32'h12345678);
      add_tr(1, 1'b1, 1'b0, 32'h40000004, 32'h0BADF00D, 0, 32'h0);
      expc(0, 0, 1);
      for (int k = 0; k < 8; k++) expc(1, 0, 1);
      expc(2, 1, 0); expc(0, 0, 0);
      run(11);

      // Reset while m1 owns the bus with a read in flight.
      test_name = "reset_mid_read";
      m1_req = 1'b1; m1_write = 1'b0; m1_lock = 1'b0; m1_addr = 32'h7000;
      next_cycle();
      chk("m1_ack_before_reset", m1_ack, 1'b1);
      chk("state_before_reset", state_o, OWN1);
      reset = 1'b1;
      next_cycle();
      chk("state", state_o, IDLE);
      chk("acks", {m1_ack, m0_ack}, 2'b00);
      chk("strobes", {Device_Write, Device_Read}, 2'b00);
      chk("rvalids", {m1_rvalid, m0_rvalid}, 2'b00);
      m1_req = 1'b0;
      reset = 1'b0;
      next_cycle();
      next_cycle();

      test_name = "end";
      chk("wr_q_empty", wr_q.size(), 0);
      chk("rd0_q_empty", rd0_q.size(), 0);
      chk("rd1_q_empty", rd1_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
